instr_encoder: RTL
==================

// Module: instr_encoder
// PURPOSE
//  RV32I instruction encoder: the inverse of the main/ALU decoder. Accepts field-level descriptions
//  (class, funct3, funct7b, rd/rs1/rs2, 32-bit immediate) on a valid/ready stream and emits packed
//  32-bit instruction words with byte addresses, to preload instruction memory.
//  Sits between the testbench/boot-loader source and the imem write port.
//  Buffers up to 2 words; range-checks immediates; drops unencodable requests and flags them.
// PARAMETERS
//  ADDR_W    10   byte-address width of out_addr; address wraps modulo 2**ADDR_W
//  BASE_RST  0    value loaded into the address counter at reset
// PORTS
//  clk        in   1   clock, all state updates on rising edge
//  rst_n      in   1   asynchronous, active-low reset
//  start      in   1   1-cycle pulse: flush buffer, addr <= base_addr, clear err
//  base_addr  in   ADDR_W  start address, low 2 bits ignored (forced 0)
//  in_valid   in   1   request valid
//  in_ready   out  1   encoder can accept a request this cycle
//  in_kind    in   4   instr class (enc_kind_e: LOAD,OPIMM,AUIPC,STORE,OP,LUI,BRANCH,JALR,JAL)
//  in_funct3  in   3   funct3 (forced 000 for JALR, 010 for LOAD/STORE)
//  in_funct7b in   1   instr[30]: SUB/SRA/SRAI select; ignored for other kinds
//  in_rd      in   5   destination register
//  in_rs1     in   5   source register 1
//  in_rs2     in   5   source register 2
//  in_imm     in   32  immediate as its full signed/byte value (U: upper-20 value incl. zeros)
//  out_valid  out  1   out_instr/out_addr valid
//  out_ready  in   1   consumer accepts word
//  out_instr  out  32  encoded instruction
//  out_addr   out  ADDR_W byte address for out_instr
//  err        out  1   sticky: >=1 request dropped since reset/start
//  count      out  ADDR_W-2 number of words emitted (handshaken) since reset/start, wraps
// BEHAVIOUR
//  - Reset: out_valid=0, in_ready=1, err=0, count=0, addr counter=BASE_RST, buffer empty.
//  - Reset asserted mid-transfer: buffer contents discarded; no partial word emitted.
//  - Accept when in_valid&in_ready. Encoding is combinational on accept; word registered into a
//    2-entry FIFO. Latency 1: accepted at edge N -> out_valid=1 after edge N (if FIFO was empty).
//  - in_ready = FIFO not full, OR full with out_ready=1 this cycle (simultaneous push/pop allowed).
//  - out_valid/out_instr/out_addr stable while out_valid&~out_ready. Pop on out_valid&out_ready.
//  - Address assigned at accept time: word gets addr, then addr += 4 mod 2**ADDR_W. Dropped
//    requests do not consume an address.
//  - Legality checks (fail -> consumed, not enqueued, err<=1):
//    I/LOAD/JALR/STORE: imm[31:11] all equal. BRANCH: imm[31:12] equal, imm[0]=0.
//    JAL: imm[31:20] equal, imm[0]=0. AUIPC/LUI: imm[11:0]=0.
//    OPIMM shifts (f3 001/101): imm[31:5]=0. f3=001 with funct7b=1: illegal. Undefined kind: illegal.
//  - Field packing per RV32I formats R/I/S/B/U/J; opcodes from shared package (same values the
//    decoder consumes). OP: instr[30]=funct7b only for f3 000/101, else 0.
//  - start: highest priority over same-cycle accept (request not accepted; in_ready=0 that cycle);
//    FIFO flushed, out_valid=0 next cycle, err=0, count=0.
//  - count increments on output handshake; wraps at 2**(ADDR_W-2).
//  - FSM: IDLE(empty) / ONE / FULL by occupancy; no other states.
// STRUCTURE
//  - rv_pkg: opcode localparams (LOAD=0000011 ... JAL=1101111), enc_kind_e enum, format helpers.
//  - Sub-module enc_fifo2 (2-entry valid/ready FIFO, width 32+ADDR_W); encode/check logic inline.
// TESTING
//  - OPIMM f3=000 rd=1 rs1=0 imm=5 -> out_instr=0x00500093, out_addr=0, 1-cycle latency.
//  - LOAD rd=2 rs1=1 imm=8 -> 0x0080A103; STORE rs1=1 rs2=2 imm=12 -> 0x0020A623, addrs 4,8.
//  - BRANCH f3=000 rs1=1 rs2=2 imm=-8 -> 0xFE208CE3; JAL rd=1 imm=2048 -> 0x001000EF;
//    LUI rd=5 imm=0x12345000 -> 0x123452B7.
//  - OP f3=000 f7b=1 rd=3 rs1=1 rs2=2 -> 0x402081B3; OPIMM f3=101 f7b=1 rd=4 rs1=1 imm=3 -> 0x4030D213.
//  - OPIMM imm=2048 and BRANCH imm=3 -> no output, err=1, next legal word reuses the same address.
//  - out_ready=0, push 3 -> in_ready=0 after 2; release -> words in order; start + rst_n mid-stream flush.

Source files
------------

// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - RV32I opcodes, encoder request kinds and instruction format packing helpers
//
// Purpose: shared definitions for the RV32I decoder and encoder. The opcode values
// here are the same ones the decoder consumes.
// Contents:
//   OPC_*        7-bit major opcodes
//   enc_kind_e   instruction class accepted by instr_encoder
//   fifo_state_e occupancy states of the 2-entry output FIFO
//   fmt_*        bit packing for R/I/S/B/U/J formats
//   sext_ok      1 when v[31:lsb] are all equal (value fits a signed field)
package rv_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef enum logic [3:0] {
    K_LOAD   = 4'd0,
    K_OPIMM  = 4'd1,
    K_AUIPC  = 4'd2,
    K_STORE  = 4'd3,
    K_OP     = 4'd4,
    K_LUI    = 4'd5,
    K_BRANCH = 4'd6,
    K_JALR   = 4'd7,
    K_JAL    = 4'd8
  } enc_kind_e;

  typedef enum logic [1:0] {
    F_IDLE = 2'd0,
    F_ONE  = 2'd1,
    F_FULL = 2'd2
  } fifo_state_e;

  function automatic logic [31:0] fmt_r(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1,
                                        logic [2:0] f3, logic [4:0] rd, logic [6:0] opc);
    return {f7, rs2, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] fmt_i(logic [11:0] imm, logic [4:0] rs1, logic [2:0] f3,
                                        logic [4:0] rd, logic [6:0] opc);
    return {imm, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] fmt_s(logic [11:0] imm, logic [4:0] rs2, logic [4:0] rs1,
                                        logic [2:0] f3, logic [6:0] opc);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], opc};
  endfunction

  function automatic logic [31:0] fmt_b(logic [12:1] imm, logic [4:0] rs2, logic [4:0] rs1,
                                        logic [2:0] f3, logic [6:0] opc);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], opc};
  endfunction

  function automatic logic [31:0] fmt_u(logic [31:12] imm, logic [4:0] rd, logic [6:0] opc);
    return {imm, rd, opc};
  endfunction

  function automatic logic [31:0] fmt_j(logic [20:1] imm, logic [4:0] rd, logic [6:0] opc);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, opc};
  endfunction

  function automatic logic sext_ok(logic [31:0] v, int lsb);
    logic [31:0] s;
    s = $signed(v) >>> lsb;
    return (s == 32'h0) || (s == 32'hFFFF_FFFF);
  endfunction

endpackage

// File: rtl/enc_fifo2.sv
// rtl/enc_fifo2.sv - 2-entry valid/ready FIFO with flush, occupancy FSM IDLE/ONE/FULL
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   flush                 empties the FIFO on the next edge (wins over push/pop)
//   in_valid/in_ready/in_data     write side; in_ready also high when full and popping
//   out_valid/out_ready/out_data  read side; out_data is the head entry (slot0)
module enc_fifo2
  import rv_pkg::*;
#(
  parameter int W = 42
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  fifo_state_e state, state_nx;
  logic [W-1:0] slot0, slot1;
  logic push, pop;

  assign out_valid = (state != F_IDLE);
  assign in_ready  = (state != F_FULL) || out_ready;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_data  = slot0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= F_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (flush) begin
      state_nx = F_IDLE;
    end else begin
      case (state)
        F_IDLE:  if (push) state_nx = F_ONE;
        F_ONE:   if (push && !pop) state_nx = F_FULL;
                 else if (!push && pop) state_nx = F_IDLE;
        F_FULL:  if (pop && !push) state_nx = F_ONE;
        default: state_nx = F_IDLE;
      endcase
    end
  end

  // slot0 is always the head; a pop shifts slot1 down, a push lands in the
  // first slot that is free after the pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot0 <= '0;
      slot1 <= '0;
    end else if (!flush) begin
      case (state)
        F_IDLE: if (push) slot0 <= in_data;
        F_ONE: begin
          if (push && pop)  slot0 <= in_data;
          else if (push)    slot1 <= in_data;
        end
        F_FULL: begin
          if (pop) slot0 <= slot1;
          if (push) slot1 <= in_data;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - RV32I field-level request to packed instruction word encoder
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   start           flush buffer, reload address from base_addr, clear err and count
//   base_addr       start byte address (low 2 bits forced 0)
//   in_*            request stream (kind, funct3, funct7b, rd, rs1, rs2, imm)
//   out_*           encoded word stream with byte address
//   err             sticky: some request was dropped as unencodable
//   count           words handed off since reset/start
module instr_encoder
  import rv_pkg::*;
#(
  parameter int ADDR_W   = 10,
  parameter int BASE_RST = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_kind,
  input  logic [2:0]        in_funct3,
  input  logic              in_funct7b,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err,
  output logic [ADDR_W-3:0] count
);

  logic [ADDR_W-1:0] addr;
  logic [31:0]       instr;
  logic              legal, is_shift, fifo_ready, accept, push, pop;
  logic [31+ADDR_W:0] fifo_out;

  assign is_shift = (in_funct3 == 3'b001) || (in_funct3 == 3'b101);

  always_comb begin
    instr = '0;
    legal = 1'b0;
    case (in_kind)
      K_LOAD: begin
        instr = fmt_i(in_imm[11:0], in_rs1, 3'b010, in_rd, OPC_LOAD);
        legal = sext_ok(in_imm, 11);
      end
      K_OPIMM: begin
        if (is_shift) begin
          // funct7b only selects SRAI; SLLI with bit30 set has no encoding.
          instr = fmt_i({1'b0, in_funct7b && in_funct3[2], 5'b0, in_imm[4:0]},
                        in_rs1, in_funct3, in_rd, OPC_OPIMM);
          legal = (in_imm[31:5] == '0) && !(in_funct3 == 3'b001 && in_funct7b);
        end else begin
          instr = fmt_i(in_imm[11:0], in_rs1, in_funct3, in_rd, OPC_OPIMM);
          legal = sext_ok(in_imm, 11);
        end
      end
      K_AUIPC: begin
        instr = fmt_u(in_imm[31:12], in_rd, OPC_AUIPC);
        legal = (in_imm[11:0] == '0);
      end
      K_STORE: begin
        instr = fmt_s(in_imm[11:0], in_rs2, in_rs1, 3'b010, OPC_STORE);
        legal = sext_ok(in_imm, 11);
      end
      K_OP: begin
        instr = fmt_r({1'b0, in_funct7b && (in_funct3 == 3'b000 || in_funct3 == 3'b101), 5'b0},
                      in_rs2, in_rs1, in_funct3, in_rd, OPC_OP);
        legal = 1'b1;
      end
      K_LUI: begin
        instr = fmt_u(in_imm[31:12], in_rd, OPC_LUI);
        legal = (in_imm[11:0] == '0);
      end
      K_BRANCH: begin
        instr = fmt_b(in_imm[12:1], in_rs2, in_rs1, in_funct3, OPC_BRANCH);
        legal = sext_ok(in_imm, 12) && !in_imm[0];
      end
      K_JALR: begin
        instr = fmt_i(in_imm[11:0], in_rs1, 3'b000, in_rd, OPC_JALR);
        legal = sext_ok(in_imm, 11);
      end
      K_JAL: begin
        instr = fmt_j(in_imm[20:1], in_rd, OPC_JAL);
        legal = sext_ok(in_imm, 20) && !in_imm[0];
      end
      default: ;
    endcase
  end

  // start owns the cycle: nothing is accepted while the buffer is being flushed.
  assign in_ready = fifo_ready && !start;
  assign accept   = in_valid && in_ready;
  assign push     = accept && legal;
  assign pop      = out_valid && out_ready;

  enc_fifo2 #(.W(32 + ADDR_W)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (start),
    .in_valid  (push),
    .in_ready  (fifo_ready),
    .in_data   ({instr, addr}),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (fifo_out)
  );

  assign out_instr = fifo_out[31+ADDR_W:ADDR_W];
  assign out_addr  = fifo_out[ADDR_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr  <= ADDR_W'(BASE_RST);
      err   <= 1'b0;
      count <= '0;
    end else if (start) begin
      addr  <= base_addr & ~ADDR_W'(3);
      err   <= 1'b0;
      count <= '0;
    end else begin
      if (push) addr <= addr + ADDR_W'(4);
      if (accept && !legal) err <= 1'b1;
      if (pop) count <= count + 1'b1;
    end
  end

endmodule
